led_monitor: RTL and testbench
==============================

# led_monitor

Slow-control readback for the front-panel LED bus. The block samples the 16-bit `led_out` vector driven by the LED controller and counts LED transitions over a fixed time window. It latches per-LED activity snapshots and serves them to the slow-control register bus through a single-outstanding request/response handshake. With it, the DAQ can confirm remotely which status LEDs (TTC flashes, clock blinkers, rate bar) are alive.

## Interface
Parameters:
- `MXLED`, 16, number of LED lines monitored.
- `WINDOW_CNT`, 40079000, window length in `clock` cycles (1 s at LHC 40.079 MHz).
- `CNT_WIDTH`, 16, width of each per-LED transition counter (saturating).

Ports (one clock; reset is synchronous and active-low):
- `clock`  in  1  LHC 40 MHz fabric clock; all logic on rising edge.
- `reset_n`  in  1  synchronous active-low reset.
- `led_i`  in  MXLED  LED vector; may contain bits from the asynchronous oscillator domain.
- `req_valid_i`  in  1  read request strobe.
- `req_addr_i`  in  5  register address.
- `req_ready_o`  out  1  block can accept a request this cycle.
- `rsp_valid_o`  out  1  one-cycle response strobe.
- `rsp_data_o`  out  32  read data, valid when `rsp_valid_o`=1.

## Operation
- Input conditioning: 2-flop synchronizer on every `led_i` bit, followed by a 1-flop previous-value register for edge detection.
- Edge detection: rising edges only (see Configuration). One edge per LED per cycle at most.
- Live counters: `MXLED` counters, each `CNT_WIDTH` wide. Each counter increments on its LED's edge and saturates at 2^CNT_WIDTH-1 (no wrap).
- Window timer: counts 0..WINDOW_CNT-1, then wraps. On the terminal cycle (timer = WINDOW_CNT-1):
  - every live counter is copied to its snapshot register;
  - `window_num` (32 b, wraps 0xFFFFFFFF->0) increments.
- Edge coinciding with the terminal cycle: that edge is not in the snapshot. The live counter restarts at 1 instead of 0.
- Register map (`req_addr_i`):
  - 0..MXLED-1: snapshot count for LED n, zero-extended.
  - 16: {16'h0, synchronized live levels}.
  - 17: {16'h0, active mask}; bit n = (snapshot n != 0).
  - 18: `window_num`.
  - 19..31: 32'h0000_0000.
- Handshake FSM, two states:
  - IDLE: `req_ready_o`=1. If `req_valid_i`=1, the request is accepted: data is captured from register state as of that edge, then go to RESP.
  - RESP: `req_ready_o`=0, `rsp_valid_o`=1, `rsp_data_o` holds the captured data; return to IDLE next cycle.
  - `req_valid_i` during RESP is ignored; the requester must hold or retry.
- Snapshot update and read in the same cycle: the read returns the old snapshot, i.e. the value before the terminal-cycle copy.

## Timing
- Reset values:
  - `req_ready_o`=0, `rsp_valid_o`=0, `rsp_data_o`=0;
  - all counters, snapshots, window timer and `window_num` = 0;
  - synchronizer and edge flops = 0.
- `req_ready_o` rises on the first edge with `reset_n`=1.
- `led_i` edge sampled at clock edge k -> live counter updated at edge k+3. This is synchronizer (2) plus edge register (1).
- Request accepted at edge k -> `rsp_valid_o`=1 during cycle k..k+1 (1-cycle latency).
- Maximum throughput: one request per 2 cycles.
- Reset mid-operation (`reset_n`=0 at any edge): all state returns to reset values on that edge.
  - A pending RESP is dropped and no `rsp_valid_o` is issued.
  - The window restarts from 0.
- Snapshot copy and `window_num` increment occur on the same edge.

## Configuration
- `LED_MONITOR_BOTH_EDGES_EN`:
  - Defined: counters increment on both rising and falling edges, so a 2 Hz blinker gives 4 counts/s.
  - Undefined: rising edges only, so the same blinker gives 2 counts/s.
- Register map and timing are identical in both builds.

## Test plan
- Reset: hold `reset_n`=0 for 5 cycles with random `led_i` -> all outputs 0. `req_ready_o`=1 on the first cycle after release. Reads of addr 0..18 return 0.
- Counting (WINDOW_CNT=100, macro off): toggle `led_i[14]` every 10 cycles -> after the first full window, addr 14 returns 5, addr 17 returns 0x4000 and addr 18 returns 1.
- Saturation (CNT_WIDTH=4, WINDOW_CNT=200): 0/1 pattern on `led_i[0]` every 2 cycles -> addr 0 reads 15, not wrapped.
- Boundary: rising edge on `led_i[3]` whose counter update lands on the terminal cycle -> snapshot excludes it. The next window's snapshot includes it, with that LED idle otherwise, and reads 1.
- Handshake: `req_valid_i` held high for 6 cycles at addr 16 with `led_i`=16'hA5A5 static -> exactly 3 `rsp_valid_o` pulses, each with data 0x0000A5A5, and `req_ready_o` alternating 1/0.
- Macro on: 2 Hz-equivalent blinker (toggle every 25 cycles, WINDOW_CNT=100) -> addr reads 4 (macro off: 2).

Source files
------------

// File: rtl/led_monitor.sv
// led_monitor: per-LED transition counters over a fixed window, snapshotted and read back
// through a single-outstanding request/response port. Define LED_MONITOR_BOTH_EDGES_EN to count falling edges too.
module led_monitor #(
  parameter int unsigned MXLED      = 16,
  parameter int unsigned WINDOW_CNT = 40079000,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [MXLED-1:0] led_i,
  input  logic             req_valid_i,
  input  logic [4:0]       req_addr_i,
  output logic             req_ready_o,
  output logic             rsp_valid_o,
  output logic [31:0]      rsp_data_o
);

  localparam int unsigned          TW      = (WINDOW_CNT > 1) ? $clog2(WINDOW_CNT) : 1;
  localparam logic [TW-1:0]        TERM    = TW'(WINDOW_CNT - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic {S_IDLE, S_RESP} state_t;

  state_t               state_q;
  logic                 ready_q, rsp_valid_q;
  logic [31:0]          rsp_data_q;
  logic [MXLED-1:0]     sync1_q, sync2_q, prev_q, edge_q, edge_d;
  logic [CNT_WIDTH-1:0] live_q [MXLED];
  logic [CNT_WIDTH-1:0] snap_q [MXLED];
  logic [TW-1:0]        timer_q;
  logic [31:0]          window_num_q;
  logic                 terminal;
  logic [MXLED-1:0]     active;
  logic [31:0]          rd_data;

  // Edge pulse is registered so a led_i change reaches its counter three edges later.
  always_comb begin
`ifdef LED_MONITOR_BOTH_EDGES_EN
    edge_d = sync2_q ^ prev_q;
`else
    edge_d = sync2_q & ~prev_q;
`endif
  end

  assign terminal = (timer_q == TERM);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      prev_q       <= '0;
      edge_q       <= '0;
      timer_q      <= '0;
      window_num_q <= '0;
      for (int unsigned n = 0; n < MXLED; n++) begin
        live_q[n] <= '0;
        snap_q[n] <= '0;
      end
    end else begin
      sync1_q <= led_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      edge_q  <= edge_d;
      timer_q <= terminal ? '0 : timer_q + 1'b1;
      if (terminal) window_num_q <= window_num_q + 32'd1;
      // An edge landing on the terminal cycle seeds the next window instead of this snapshot.
      for (int unsigned n = 0; n < MXLED; n++) begin
        if (terminal) begin
          snap_q[n] <= live_q[n];
          live_q[n] <= CNT_WIDTH'(edge_q[n]);
        end else if (edge_q[n] && (live_q[n] != CNT_MAX)) begin
          live_q[n] <= live_q[n] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    for (int unsigned n = 0; n < MXLED; n++) begin
      active[n] = (snap_q[n] != '0);
    end
  end

  always_comb begin
    rd_data = '0;
    for (int unsigned n = 0; n < MXLED; n++) begin
      if (req_addr_i == 5'(n)) rd_data[CNT_WIDTH-1:0] = snap_q[n];
    end
    case (req_addr_i)
      5'd16:   rd_data[MXLED-1:0] = sync2_q;
      5'd17:   rd_data[MXLED-1:0] = active;
      5'd18:   rd_data = window_num_q;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ready_q && req_valid_i) begin
            state_q     <= S_RESP;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= rd_data;
          end else begin
            ready_q <= 1'b1;
          end
        end
        S_RESP: begin
          state_q     <= S_IDLE;
          ready_q     <= 1'b1;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready_o = ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;

endmodule

// File: tb/tb_led_monitor.sv
// Directed bench for led_monitor: dut_a (WINDOW_CNT=100) for counting, boundary and handshake,
// dut_b (CNT_WIDTH=4, WINDOW_CNT=200) for saturation.
module tb_led_monitor;

`ifdef LED_MONITOR_BOTH_EDGES_EN
  localparam logic [31:0] EXP14 = 32'd10;
  localparam logic [31:0] EXP7  = 32'd4;
`else
  localparam logic [31:0] EXP14 = 32'd5;
  localparam logic [31:0] EXP7  = 32'd2;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] led_a = '0, led_b = '0;
  logic        req_valid_a = 1'b0, req_valid_b = 1'b0;
  logic [4:0]  req_addr_a = '0, req_addr_b = '0;
  logic        ready_a, ready_b, rsp_valid_a, rsp_valid_b;
  logic [31:0] rsp_data_a, rsp_data_b;

  int unsigned cyc = 0;
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  bit          tog_b = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  led_monitor #(.MXLED(16), .WINDOW_CNT(100), .CNT_WIDTH(16)) dut_a (
    .clock(clk), .reset_n(reset_n), .led_i(led_a),
    .req_valid_i(req_valid_a), .req_addr_i(req_addr_a),
    .req_ready_o(ready_a), .rsp_valid_o(rsp_valid_a), .rsp_data_o(rsp_data_a)
  );

  led_monitor #(.MXLED(16), .WINDOW_CNT(200), .CNT_WIDTH(4)) dut_b (
    .clock(clk), .reset_n(reset_n), .led_i(led_b),
    .req_valid_i(req_valid_b), .req_addr_i(req_addr_b),
    .req_ready_o(ready_b), .rsp_valid_o(rsp_valid_b), .rsp_data_o(rsp_data_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (tog_b) led_b = {15'b0, cyc[1]};
  endtask

  task automatic wait_until(input int unsigned n);
    int unsigned g = 0;
    while (cyc < n && g < 1000) begin
      tick();
      g++;
    end
    chk("schedule", cyc, n);
  endtask

  task automatic rd(input bit b, input logic [4:0] a, input logic [31:0] exp, input string tag);
    int unsigned g = 0;
    logic [31:0] d;
    while (((b ? ready_b : ready_a) !== 1'b1) && g < 8) begin
      tick();
      g++;
    end
    chk({tag, "_ready"}, 32'(b ? ready_b : ready_a), 32'd1);
    if (b) begin req_valid_b = 1'b1; req_addr_b = a; end
    else   begin req_valid_a = 1'b1; req_addr_a = a; end
    tick();
    chk({tag, "_rspv"}, 32'(b ? rsp_valid_b : rsp_valid_a), 32'd1);
    d = b ? rsp_data_b : rsp_data_a;
    req_valid_a = 1'b0;
    req_valid_b = 1'b0;
    chk(tag, d, exp);
  endtask

  initial begin
    int unsigned pulses;
    logic exp_v;

    // Reset held 5 cycles with random LEDs
    for (int i = 0; i < 5; i++) begin
      led_a = 16'($urandom);
      led_b = 16'($urandom);
      tick();
    end
    chk("rst_ready_a", 32'(ready_a), 32'd0);
    chk("rst_rspv_a", 32'(rsp_valid_a), 32'd0);
    chk("rst_data_a", rsp_data_a, 32'd0);
    chk("rst_ready_b", 32'(ready_b), 32'd0);
    reset_n = 1'b1;
    led_a = '0;
    led_b = '0;
    tick();
    chk("rel_ready_a", 32'(ready_a), 32'd1);
    chk("rel_ready_b", 32'(ready_b), 32'd1);
    for (int unsigned a = 0; a <= 18; a++) begin
      rd(1'b0, 5'(a), 32'd0, $sformatf("rst_addr%0d", a));
    end

    // Mid-operation reset with a request on the same edge: no response
    tick();
    req_valid_a = 1'b1;
    req_addr_a  = 5'd18;
    reset_n     = 1'b0;
    tick();
    chk("midrst_rspv", 32'(rsp_valid_a), 32'd0);
    chk("midrst_ready", 32'(ready_a), 32'd0);
    req_valid_a = 1'b0;
    tick();
    reset_n = 1'b1;
    led_a   = 16'h4000;
    tog_b   = 1'b1;

    // led[14] toggles every 10 cycles through window 1
    for (int unsigned i = 1; i <= 9; i++) begin
      wait_until(10 * i);
      led_a[14] = ~led_a[14];
    end
    wait_until(101);
    rd(1'b0, 5'd14, EXP14, "w1_addr14");
    rd(1'b0, 5'd17, 32'h0000_4000, "w1_mask");
    rd(1'b0, 5'd18, 32'd1, "w1_winnum");

    // led[3] rises so its counter update lands on the terminal edge 200
    wait_until(196);
    led_a[3] = 1'b1;
    wait_until(201);
    rd(1'b0, 5'd3, 32'd0, "w2_addr3");
    rd(1'b0, 5'd14, 32'd0, "w2_addr14");
    rd(1'b0, 5'd17, 32'd0, "w2_mask");
    rd(1'b1, 5'd0, 32'd15, "sat_addr0");
    rd(1'b1, 5'd17, 32'd1, "sat_mask");
    rd(1'b1, 5'd18, 32'd1, "sat_winnum");

    // Read accepted on the snapshot edge returns the old snapshot
    wait_until(299);
    chk("w3_edge_ready", 32'(ready_a), 32'd1);
    req_valid_a = 1'b1;
    req_addr_a  = 5'd3;
    tick();
    req_valid_a = 1'b0;
    led_a[7] = 1'b1;
    chk("w3_edge_rspv", 32'(rsp_valid_a), 32'd1);
    chk("w3_edge_old", rsp_data_a, 32'd0);
    rd(1'b0, 5'd3, 32'd1, "w3_addr3");
    rd(1'b0, 5'd17, 32'h0000_0008, "w3_mask");
    rd(1'b0, 5'd18, 32'd3, "w3_winnum");

    // led[7] blinker toggling every 25 cycles through window 4
    wait_until(325);
    led_a[7] = 1'b0;
    wait_until(350);
    led_a[7] = 1'b1;
    wait_until(375);
    led_a[7] = 1'b0;
    wait_until(401);
    rd(1'b0, 5'd7, EXP7, "w4_addr7");
    rd(1'b0, 5'd3, 32'd0, "w4_addr3");
    rd(1'b0, 5'd17, 32'h0000_0080, "w4_mask");
    rd(1'b0, 5'd18, 32'd4, "w4_winnum");
    rd(1'b0, 5'd25, 32'd0, "unmapped25");

    // Back-to-back requests held for 6 cycles at addr 16
    led_a = 16'hA5A5;
    tick();
    tick();
    tick();
    chk("hs_ready0", 32'(ready_a), 32'd1);
    req_valid_a = 1'b1;
    req_addr_a  = 5'd16;
    pulses = 0;
    for (int unsigned i = 1; i <= 6; i++) begin
      tick();
      exp_v = (i % 2 == 1);
      chk($sformatf("hs_ready%0d", i), 32'(ready_a), 32'(!exp_v));
      chk($sformatf("hs_rspv%0d", i), 32'(rsp_valid_a), 32'(exp_v));
      if (rsp_valid_a === 1'b1) begin
        pulses++;
        chk($sformatf("hs_data%0d", i), rsp_data_a, 32'h0000_A5A5);
      end
    end
    req_valid_a = 1'b0;
    chk("hs_pulses", pulses, 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
